// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and auto-repeat a bank of active-low push-buttons
// Ports:
//   clock, reset_bar - rising-edge clock, asynchronous active-low reset
//   key_n            - raw asynchronous key levels, 0 = pressed
//   repeat_en        - per-key auto-repeat enable
//   press_pulse      - one-cycle pulse per accepted press or auto-repeat event
//   release_pulse    - one-cycle pulse per accepted release
//   held, any_held   - debounced pressed level per key, and their OR
//   active_idx       - index of the lowest held key, 0 when none
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int EXCLUSIVE       = 1,
    localparam int AW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clock,
    input  logic                reset_bar,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] held,
    output logic                any_held,
    output logic [AW-1:0]       active_idx
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    logic [NUM_KEYS-1:0] w_p;
    logic [NUM_KEYS-1:0] w_busy;
    logic [NUM_KEYS-1:0] w_grant;
    logic                w_seen;

    // Exclusive mode: an idle key may start only when every key is idle and
    // no lower-indexed key is requesting on the same edge.
    always_comb begin
        w_grant = '0;
        w_seen  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_grant[i] = (EXCLUSIVE == 0) || (!(|w_busy) && !w_seen);
            w_seen     = w_seen | w_p[i];
        end
    end

    always_comb begin
        active_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (held[i]) active_idx = AW'(i);
    end

    assign any_held = |held;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        logic [DW-1:0]          r_cnt;
        logic [RW-1:0]          r_rpt;
        logic                   r_rph;
        logic                   r_press;
        logic                   r_release;

        assign w_p[g]           = ~r_sync[SYNC_STAGES-1];
        assign w_busy[g]        = r_state != IDLE;
        assign held[g]          = (r_state == HELD) || (r_state == RELEASE_DB);
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;

        // r_rph selects the repeat target: first the initial delay, then the period.
        always_ff @(posedge clock or negedge reset_bar) begin
            if (!reset_bar) begin
                r_sync    <= '1;
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_rpt     <= '0;
                r_rph     <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], key_n[g]};
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_rpt     <= '0;
                r_rph     <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_p[g] && w_grant[g]) begin
                            r_state <= PRESS_DB;
                            r_cnt   <= DW'(1);
                        end
                    end
                    PRESS_DB: begin
                        if (!w_p[g]) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                            r_state <= HELD;
                            r_cnt   <= '0;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!w_p[g]) begin
                            r_state <= RELEASE_DB;
                            r_cnt   <= DW'(1);
                        end else if (repeat_en[g]) begin
                            if (r_rpt == (r_rph ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                                r_press <= 1'b1;
                                r_rph   <= 1'b1;
                            end else begin
                                r_rpt <= r_rpt + 1'b1;
                                r_rph <= r_rph;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (w_p[g]) begin
                            r_state <= HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table-driven and scoreboarded bench for key_conditioner
module tb_key_conditioner;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = 5;

    typedef struct {
        int ch;
        int len;
        bit rep;
        int n_press;
        bit exp_held;
    } vec_t;

    typedef struct {
        int cyc;
        int ch;
        bit rel;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset_bar;
    logic [3:0] key_n;
    logic [3:0] repeat_en;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] held;
    logic       any_held;
    logic [1:0] active_idx;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   k;
    int   r;
    ev_t  exp_q[$];
    ev_t  mon_e;
    vec_t vecs[15];

    key_conditioner #(
        .NUM_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .EXCLUSIVE(1)
    ) dut (
        .clock(clock), .reset_bar(reset_bar), .key_n(key_n), .repeat_en(repeat_en),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .held(held),
        .any_held(any_held), .active_idx(active_idx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int ch, input bit rel);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] status();
        return {25'd0, held, any_held, active_idx};
    endfunction

    initial begin
        vecs = '{
            '{0, 20, 1'b0, 1, 1'b1},
            '{1,  1, 1'b0, 0, 1'b0},
            '{1,  2, 1'b0, 0, 1'b0},
            '{1,  3, 1'b0, 0, 1'b0},
            '{1,  3, 1'b0, 0, 1'b0},
            '{1,  3, 1'b0, 0, 1'b0},
            '{1,  3, 1'b0, 0, 1'b0},
            '{1,  3, 1'b0, 0, 1'b0},
            '{2,  4, 1'b0, 1, 1'b0},
            '{2,  5, 1'b0, 1, 1'b0},
            '{2,  6, 1'b0, 1, 1'b1},
            '{1, 13, 1'b1, 1, 1'b1},
            '{1, 14, 1'b1, 2, 1'b1},
            '{3, 30, 1'b1, 7, 1'b1},
            '{0, 16, 1'b0, 1, 1'b1}
        };
        reset_bar = 1'b0;
        key_n     = '1;
        repeat_en = '0;

        fork
            forever begin
                @(negedge clock);
                if ((press_pulse | release_pulse) != '0)
                    chk("no_overlap", {28'd0, press_pulse & release_pulse}, 32'd0);
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 2; j++)
                        if (j == 0 ? press_pulse[i] : release_pulse[i]) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_pulse: ch %0d rel %0d at edge %0d, required none", i, j, cyc);
                            end else begin
                                mon_e = exp_q.pop_front();
                                chk("pulse_edge_ch_rel", cyc * 16 + i * 2 + j,
                                    mon_e.cyc * 16 + mon_e.ch * 2 + int'(mon_e.rel));
                            end
                        end
            end
        join_none

        tick(3);
        chk("reset_outputs", {17'd0, held, any_held, active_idx, press_pulse, release_pulse}, 32'd0);
        reset_bar = 1'b1;
        tick(3);

        for (int n = 0; n < 15; n++) begin
            k = cyc + 1;
            key_n[vecs[n].ch]     = 1'b0;
            repeat_en[vecs[n].ch] = vecs[n].rep;
            if (vecs[n].n_press > 0) push(k + LAT, vecs[n].ch, 1'b0);
            for (int m = 1; m < vecs[n].n_press; m++)
                push(k + LAT + RD + (m - 1) * RP, vecs[n].ch, 1'b0);
            tick(vecs[n].len);
            chk("held_status", status(),
                vecs[n].exp_held ? ((32'd1 << vecs[n].ch) << 3) | 32'd4 | vecs[n].ch : 32'd0);
            if (vecs[n].n_press > 0) push(cyc + 1 + LAT, vecs[n].ch, 1'b1);
            key_n[vecs[n].ch] = 1'b1;
            tick(12);
            repeat_en[vecs[n].ch] = 1'b0;
        end

        k = cyc + 1;
        key_n[1] = 1'b0;
        key_n[2] = 1'b0;
        push(k + 5, 1, 1'b0);
        tick(7);
        chk("excl_ch1_only", status(), {25'd0, 4'b0010, 1'b1, 2'd1});
        tick(3);
        key_n[1] = 1'b1;
        push(k + 15, 1, 1'b1);
        push(k + 19, 2, 1'b0);
        tick(11);
        chk("excl_ch2_after", status(), {25'd0, 4'b0100, 1'b1, 2'd2});
        tick(4);
        key_n[2] = 1'b1;
        push(k + 30, 2, 1'b1);
        tick(12);

        k = cyc + 1;
        key_n[3]     = 1'b0;
        repeat_en[3] = 1'b1;
        push(k + 5, 3, 1'b0);
        push(k + 15, 3, 1'b0);
        push(k + 18, 3, 1'b0);
        tick(20);
        repeat_en[3] = 1'b0;
        tick(20);
        chk("repeat_stopped_held", status(), {25'd0, 4'b1000, 1'b1, 2'd3});
        key_n[3] = 1'b1;
        push(k + 45, 3, 1'b1);
        tick(12);

        k = cyc + 1;
        key_n[3]     = 1'b0;
        repeat_en[3] = 1'b1;
        push(k + 5, 3, 1'b0);
        tick(13);
        chk("pre_reset_held", status(), {25'd0, 4'b1000, 1'b1, 2'd3});
        reset_bar = 1'b0;
        #1;
        chk("mid_repeat_reset", {17'd0, held, any_held, active_idx, press_pulse, release_pulse}, 32'd0);
        tick(2);
        key_n[3]     = 1'b1;
        repeat_en[3] = 1'b0;
        reset_bar    = 1'b1;
        tick(12);

        k = cyc + 1;
        key_n[0] = 1'b0;
        tick(4);
        reset_bar = 1'b0;
        #1;
        chk("mid_debounce_reset", {17'd0, held, any_held, active_idx, press_pulse, release_pulse}, 32'd0);
        tick(2);
        reset_bar = 1'b1;
        r = cyc;
        push(r + 6, 0, 1'b0);
        tick(15);
        chk("post_reset_held", status(), {25'd0, 4'b0001, 1'b1, 2'd0});
        key_n[0] = 1'b1;
        push(cyc + 1 + LAT, 0, 1'b1);
        tick(20);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent key channels, range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronised samples required to accept a press or release, range 2..2^20.
REQ-004 Parameter REPEAT_DELAY, default 25000000: cycles from HELD entry to the first auto-repeat pulse, minimum 2.
REQ-005 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses, minimum 2.
REQ-006 Parameter EXCLUSIVE, default 1: 1 means only one channel may be outside IDLE at a time; 0 means channels are independent.
REQ-007 clock  input  1  single system clock; all flops are on its rising edge.
REQ-008 reset_bar  input  1  asynchronous, active-low reset; assertion acts immediately, deassertion is sampled on clock.
REQ-009 key_n  input  NUM_KEYS  raw asynchronous push-button levels; 0 means pressed.
REQ-010 repeat_en  input  NUM_KEYS  per-channel auto-repeat enable, synchronous to clock.
REQ-011 press_pulse  output  NUM_KEYS  one-cycle pulse per accepted press or per auto-repeat event.
REQ-012 release_pulse  output  NUM_KEYS  one-cycle pulse per accepted release.
REQ-013 held  output  NUM_KEYS  debounced pressed level, high in HELD and RELEASE_DB.
REQ-014 any_held  output  1  OR of held.
REQ-015 active_idx  output  max(1,$clog2(NUM_KEYS))  index of the lowest channel with held high; 0 when none.

Function
REQ-016 Each channel SHALL pass key_n through SYNC_STAGES flops and invert the result to give a synchronised pressed level p.
REQ-017 Each channel FSM SHALL have the states IDLE, PRESS_DB, HELD and RELEASE_DB, plus a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
- IDLE: p=1 and the channel is permitted (REQ-019) -> PRESS_DB with cnt=1.
- PRESS_DB: p=0 -> IDLE. p=1 with cnt=DEBOUNCE_CYCLES-1 -> HELD. Otherwise cnt++.
- HELD: p=0 -> RELEASE_DB with cnt=1.
- RELEASE_DB: p=1 -> HELD with no pulse. p=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
REQ-018 The pulses SHALL be registered: press_pulse[i] is high for exactly the one cycle after the clock edge that enters HELD from PRESS_DB, and release_pulse[i] is high for the one cycle after the edge that enters IDLE from RELEASE_DB.
REQ-019 Exclusion when EXCLUSIVE=1:
- A channel may leave IDLE only if every other channel is in IDLE.
- When several IDLE channels see p=1 on the same edge, only the lowest index advances.
- The blocked channels stay in IDLE and re-evaluate every cycle.
REQ-020 Auto-repeat:
- In HELD with repeat_en[i]=1, a repeat counter SHALL count from HELD entry.
- press_pulse[i] fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
- The counter clears on leaving HELD, on repeat_en[i]=0, and when RELEASE_DB returns to HELD.
REQ-021 Latency: with key_n[i] held low from edge 1 (the first sampling edge), press_pulse[i] SHALL be high during the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-022 A bounce shorter than DEBOUNCE_CYCLES synchronised samples SHALL produce no pulse and no held change.
REQ-023 All counters SHALL saturate or clear and never wrap to produce a spurious pulse.
REQ-024 press_pulse and release_pulse SHALL never be high on the same channel in the same cycle.

Reset
REQ-025 While reset_bar=0:
- Synchroniser flops are set to 1 (unpressed).
- FSMs are in IDLE with all counters at 0.
- press_pulse, release_pulse, held, any_held and active_idx are all 0.
REQ-026 A key held low through reset deassertion SHALL require the full REQ-021 latency before producing press_pulse, measured from the first post-reset edge.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.

Verification (NUM_KEYS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, EXCLUSIVE=1)
REQ-028 key_n[0] low from edge 1 -> press_pulse[0] high for one cycle after edge 6; held[0]=1 and any_held=1 from then on; key_n[0] high again -> release_pulse[0] one cycle after a further 6 edges.
REQ-029 key_n[1] low for 3 cycles then high, repeated 5 times -> no press_pulse, held[1] stays 0.
REQ-030 key_n[1] and key_n[2] fall on the same edge -> only channel 1 pulses, active_idx=1; key_n[2] kept low after channel 1 returns to IDLE -> press_pulse[2] after 4 more samples.
REQ-031 repeat_en[3]=1, key_n[3] held for 30 cycles -> press_pulse[3] at the initial pulse, initial+10, +13, +16, ...; repeat_en[3] dropped -> pulses stop.
REQ-032 reset_bar pulsed low during PRESS_DB of channel 0 -> all outputs 0 immediately; with the key still low, press_pulse[0] occurs 6 edges after reset release.
